// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// Contents: clear-sequencer state enum, default WIDTH/DEPTH/NREAD,
// and the address-width helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_NREAD = 2;

  // Index width for a register file of the given depth.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks clr_idx over registers 1..DEPTH-1 after reset
// or on clr_req, zeroing one register per cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr_req      request a full clear (honoured only in IDLE)
//   clr_busy     high while the sequence runs (and while in reset)
//   clr_we       zero mem[clr_idx] at this edge
//   clr_idx      register index being cleared
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State and index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: step through indices, leave after DEPTH-1 is cleared.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero r0, per-register busy
// scoreboard and sequenced clear engine.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en/addr/data     writeback port (clears busy of the target)
//   rsv_en/rsv_addr     mark a register busy for a pending producer
//   rd_addr             NREAD packed read indices
//   rd_data, rd_busy    NREAD packed combinational read results
//   clr_req, clr_busy   clear request / clear in progress
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned NREAD = DEF_NREAD,
  localparam int unsigned AW   = calc_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic             rsv_ok;

  regfile_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // Updates to r0 are dropped; everything is ignored during a clear.
  assign wr_ok  = !clr_busy && wr_en  && (wr_addr  != '0);
  assign rsv_ok = !clr_busy && rsv_en && (rsv_addr != '0);

  // Storage array; contents are only zeroed by the clear engine.
  always_ff @(posedge clk) begin
    if (rst_n && clr_we) mem[clr_idx] <= '0;
    else if (wr_ok)      mem[wr_addr] <= wr_data;
  end

  // Busy scoreboard; reservation is applied last so it wins over a write.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_busy) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)  busy_q[wr_addr]  <= 1'b0;
      if (rsv_ok) busy_q[rsv_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             b;

    assign a = rd_addr[p*AW +: AW];

    // Per-port read mux: r0 reads zero, clear forces 0 / busy.
    always_comb begin
      d = (a == '0) ? '0 : mem[a];
      b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == a)) begin
        d = wr_data;
        b = 1'b0;
      end
`else
`endif
      if (clr_busy) begin
        d = '0;
        b = 1'b1;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = d;
    assign rd_busy[p]                = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32x32, 2 read ports).
// Expectations follow REGFILE_BYPASS_EN when that macro is defined.
module tb_regfile_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            clr_req;
  logic            clr_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  // Count cycles with clr_busy high; flags bad read values seen meanwhile.
  task automatic count_clear(output int n, output int bad, input int req_at);
    n = 0;
    bad = 0;
    while (clr_busy && n < 100) begin
      if (rd_data[W-1:0] !== '0 || rd_busy !== 2'b11) bad++;
      n++;
      clr_req = (n == req_at);
      step();
    end
    clr_req = 1'b0;
  endtask

  int n;
  int bad;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0; rd_addr = {5'd5, 5'd5};
    step(); step();
    check("rst_clr_busy", 32'(clr_busy), 32'd1);
    check("rst_rd_data", rd_data[W-1:0], 32'd0);
    check("rst_rd_busy", 32'(rd_busy), 32'd3);

    rst_n = 1'b1;
    #1;
    count_clear(n, bad, -1);
    check("init_clear_len", 32'(n), 32'd31);
    check("init_clear_reads", 32'(bad), 32'd0);

    bad = 0;
    for (int i = 0; i < int'(D); i++) begin
      set_rd(AW'(i), AW'(i));
      if (rd_data !== '0 || rd_busy !== 2'b00) bad++;
    end
    check("all_zero_after_init", 32'(bad), 32'd0);

    // Basic write / two-port read.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    set_rd(5'd5, 5'd5);
    check("r5_port0", rd_data[W-1:0], 32'hDEADBEEF);
    check("r5_port1", rd_data[2*W-1:W], 32'hDEADBEEF);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    step();
    wr_en = 1'b0;
    set_rd(5'd0, 5'd0);
    check("r0_stays_zero", rd_data[W-1:0], 32'd0);
    check("r0_not_busy", 32'(rd_busy), 32'd0);

    // Same-cycle write and read of r7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    step();
    wr_data = 32'hA5A5A5A5;
    set_rd(5'd7, 5'd5);
`ifdef REGFILE_BYPASS_EN
    check("r7_same_cycle", rd_data[W-1:0], 32'hA5A5A5A5);
`else
    check("r7_same_cycle", rd_data[W-1:0], 32'h11111111);
`endif
    check("r7_same_busy", 32'(rd_busy[0]), 32'd0);
    step();
    wr_en = 1'b0;
    #1;
    check("r7_after_edge", rd_data[W-1:0], 32'hA5A5A5A5);

    // Reservation then write on r9.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(5'd5, 5'd9);
    check("r9_busy_same_cycle", 32'(rd_busy[1]), 32'd0);
    step();
    rsv_en = 1'b0;
    #1;
    check("r9_busy_next", 32'(rd_busy[1]), 32'd1);
    step(); step();
    check("r9_busy_held", 32'(rd_busy[1]), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    step();
    wr_en = 1'b0;
    #1;
    check("r9_busy_after_wr", 32'(rd_busy[1]), 32'd0);
    check("r9_data_after_wr", rd_data[2*W-1:W], 32'h55);

    // Simultaneous reserve and write on r9: reservation wins.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_both_same_data", rd_data[2*W-1:W], 32'h66);
`else
    check("r9_both_same_data", rd_data[2*W-1:W], 32'h55);
`endif
    check("r9_both_same_busy", 32'(rd_busy[1]), 32'd0);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    check("r9_both_busy", 32'(rd_busy[1]), 32'd1);
    check("r9_both_data", rd_data[2*W-1:W], 32'h66);

    // Clear request with traffic ignored during CLEAR.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    step();
    wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_en = 1'b0;
    set_rd(5'd3, 5'd9);
    check("r3_pre_data", rd_data[W-1:0], 32'h77);
    check("r3_pre_busy", 32'(rd_busy[0]), 32'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    count_clear(n, bad, 10);
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    check("req_clear_len", 32'(n), 32'd31);
    check("req_clear_reads", 32'(bad), 32'd0);
    check("r3_post_data", rd_data[W-1:0], 32'd0);
    check("r3_post_busy", 32'(rd_busy[0]), 32'd0);
    check("r9_post_busy", 32'(rd_busy[1]), 32'd0);

    // Reset in the middle of a clear restarts the sequence.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_clear_busy", 32'(clr_busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    count_clear(n, bad, -1);
    check("restart_clear_len", 32'(n), 32'd31);
    set_rd(5'd5, 5'd7);
    check("restart_r5", rd_data[W-1:0], 32'd0);
    check("restart_r7", rd_data[2*W-1:W], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
